// File: rtl/tiny_cpu_bus_responder.sv
// tiny_cpu_bus_responder
// Byte-wide memory target on the tiny CPU's multiplexed address/data bus.
// An initiator transaction is an address phase followed by either a
// write-data phase or a read-data phase. Reads may be stretched by a fixed
// number of wait states. Storage is a small register RAM cleared by reset.
//
// Handshake: req_i is held high by the initiator for the whole
// transaction. ack_o pulses high for exactly one cycle when the transaction
// completes. The responder then waits for req_i to be seen low before it
// accepts another request, so a held req_i can never launch a second
// transaction. ad_oe_o/ad_o are only active in the read-data (ack) cycle.

module tiny_cpu_bus_responder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic       we_i,
    input  logic [7:0] ad_i,
    output logic [7:0] ad_o,
    output logic       ad_oe_o,
    output logic       ack_o,
    output logic [2:0] dbg_state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_RWAIT = 3'd2,
        S_RDATA = 3'd3,
        S_WACK  = 3'd4,
        S_HOLD  = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              mem_q [DEPTH];
    logic [7:0]              mem_d [DEPTH];

    // State, address, wait counter and RAM registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Next-state logic: decode the transaction, commit writes, count wait states.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    // Upper address bits are dropped, so addresses alias.
                    addr_d = ad_i[DEPTH_LOG2-1:0];
                    if (we_i) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_RWAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WDATA: begin
                if (req_i) begin
                    mem_d[addr_q] = ad_i;
                    state_d       = S_WACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RDATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RDATA, S_WACK: begin
                state_d = req_i ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state; bus is zero when not driven.
    always_comb begin
        ack_o       = (state_q == S_RDATA) || (state_q == S_WACK);
        ad_oe_o     = (state_q == S_RDATA);
        ad_o        = (state_q == S_RDATA) ? mem_q[addr_q] : 8'h00;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_tiny_cpu_bus_responder.sv
// Bench for tiny_cpu_bus_responder: two instances (0 and 2 wait states)
// driven one at a time, checked cycle by cycle against a simple byte-array
// model of the memory and the transaction timing rules.

module tb_tiny_cpu_bus_responder;

    localparam int W0 = 0;
    localparam int W1 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req    [2];
    logic       we     [2];
    logic [7:0] ad_in  [2];
    logic [7:0] ad_out [2];
    logic       oe     [2];
    logic       ack    [2];
    logic [2:0] dbg    [2];

    tiny_cpu_bus_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .we_i(we[0]), .ad_i(ad_in[0]),
        .ad_o(ad_out[0]), .ad_oe_o(oe[0]), .ack_o(ack[0]), .dbg_state_o(dbg[0])
    );

    tiny_cpu_bus_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .we_i(we[1]), .ad_i(ad_in[1]),
        .ad_o(ad_out[1]), .ad_oe_o(oe[1]), .ack_o(ack[1]), .dbg_state_o(dbg[1])
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [2][16];
    int total = 0;
    int bad = 0;

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++)
                mem_m[d][a] = 8'h00;
    endtask

    task automatic check_out(input int d, input logic e_ack, input logic e_oe,
                             input logic [7:0] e_ad, input string name);
        total++;
        if (ack[d] !== e_ack || oe[d] !== e_oe || ad_out[d] !== e_ad) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got ack=%b oe=%b ad=%02h, want ack=%b oe=%b ad=%02h",
                     name, d, $time, ack[d], oe[d], ad_out[d], e_ack, e_oe, e_ad);
        end
    endtask

    task automatic check_int(input int act, input int req_v, input string name);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req_v);
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a negedge with the DUT idle; returns the same way.
    task automatic run_txn(input int d, input bit wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] rd_exp,
                           input int hold, input bit abort, output int ack_cyc);
        int w;
        logic [7:0] e;
        w = (d == 0) ? W0 : W1;
        ack_cyc = -1;
        req[d] = 1'b1;
        we[d] = wr;
        ad_in[d] = addr;
        if (wr) begin
            @(negedge clk);
            check_out(d, 1'b0, 1'b0, 8'h00, "wr_addr");
            if (abort) begin
                req[d] = 1'b0;
                ad_in[d] = data;
                @(negedge clk);
                check_out(d, 1'b0, 1'b0, 8'h00, "wr_abort");
                return;
            end
            ad_in[d] = data;
            we[d] = 1'($urandom);
            @(negedge clk);
            check_out(d, 1'b1, 1'b0, 8'h00, "wr_ack");
            ack_cyc = cyc;
            mem_m[d][addr[3:0]] = data;
        end else begin
            exp_q.push_back(rd_exp);
            for (int i = 0; i <= w; i++) begin
                @(negedge clk);
                check_out(d, 1'b0, 1'b0, 8'h00, "rd_wait");
                if (abort) begin
                    req[d] = 1'b0;
                    void'(exp_q.pop_back());
                    @(negedge clk);
                    check_out(d, 1'b0, 1'b0, 8'h00, "rd_abort");
                    return;
                end
                ad_in[d] = 8'($urandom);
                we[d] = 1'($urandom);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            check_out(d, 1'b1, 1'b1, e, "rd_data");
            ack_cyc = cyc;
        end
        for (int i = 0; i < hold; i++) begin
            ad_in[d] = 8'($urandom);
            we[d] = 1'($urandom);
            @(negedge clk);
            check_out(d, 1'b0, 1'b0, 8'h00, "hold_no_ack");
        end
        req[d] = 1'b0;
        @(negedge clk);
        check_out(d, 1'b0, 1'b0, 8'h00, "idle");
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int c1, c2, c3, d, h;
        bit wr, ab;
        logic [7:0] a, dt;

        vecs[0]  = '{1'b1, 8'h03, 8'hA5, 8'h00, 0};
        vecs[1]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 0};
        vecs[2]  = '{1'b1, 8'h17, 8'h5A, 8'h00, 0};
        vecs[3]  = '{1'b0, 8'h07, 8'h00, 8'h5A, 0};
        vecs[4]  = '{1'b0, 8'h05, 8'h00, 8'h00, 0};
        vecs[5]  = '{1'b1, 8'h0F, 8'hFF, 8'h00, 4};
        vecs[6]  = '{1'b0, 8'h1F, 8'h00, 8'hFF, 0};
        vecs[7]  = '{1'b1, 8'h27, 8'h01, 8'h00, 0};
        vecs[8]  = '{1'b0, 8'h07, 8'h00, 8'h01, 4};
        vecs[9]  = '{1'b0, 8'h13, 8'h00, 8'hA5, 0};
        vecs[10] = '{1'b0, 8'hEF, 8'h00, 8'hFF, 1};

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            we[i] = 1'b0;
            ad_in[i] = 8'h00;
        end
        clear_model();

        // Reset state
        #1;
        check_out(0, 1'b0, 1'b0, 8'h00, "reset0");
        check_out(1, 1'b0, 1'b0, 8'h00, "reset1");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors on both wait-state settings
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 11; i++) begin
                run_txn(dd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp,
                        vecs[i].hold, 1'b0, c1);
            end
        end

        // Back-to-back minimum period, read-after-write
        run_txn(0, 1'b1, 8'h0A, 8'h3C, 8'h00, 0, 1'b0, c1);
        run_txn(0, 1'b0, 8'h0A, 8'h00, 8'h3C, 0, 1'b0, c2);
        run_txn(0, 1'b1, 8'h0B, 8'hC3, 8'h00, 0, 1'b0, c3);
        check_int(c2 - c1, 3, "period_wr_rd");
        check_int(c3 - c2, 3, "period_rd_wr");
        run_txn(1, 1'b1, 8'h0A, 8'h66, 8'h00, 0, 1'b0, c1);
        run_txn(1, 1'b0, 8'h0A, 8'h00, 8'h66, 0, 1'b0, c2);
        check_int(c2 - c1, 5, "period_wr_rd_wait2");

        // Abort: write dropped before data phase leaves memory unchanged
        run_txn(0, 1'b1, 8'h01, 8'h33, 8'h00, 0, 1'b0, c1);
        run_txn(0, 1'b1, 8'h01, 8'hCC, 8'h00, 0, 1'b1, c1);
        run_txn(0, 1'b0, 8'h01, 8'h00, 8'h33, 0, 1'b0, c1);
        run_txn(1, 1'b0, 8'h01, 8'h00, 8'h00, 0, 1'b1, c1);
        run_txn(1, 1'b0, 8'h0F, 8'h00, 8'hFF, 0, 1'b0, c1);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom);
            a  = 8'($urandom);
            dt = 8'($urandom);
            h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            ab = ($urandom_range(0, 5) == 0);
            run_txn(d, wr, a, dt, mem_m[d][a[3:0]], h, ab, c1);
        end

        // Asynchronous reset in the read-data cycle (2 wait states)
        run_txn(1, 1'b1, 8'h03, 8'h77, 8'h00, 0, 1'b0, c1);
        req[1] = 1'b1;
        we[1] = 1'b0;
        ad_in[1] = 8'h03;
        repeat (3) begin
            @(negedge clk);
            check_out(1, 1'b0, 1'b0, 8'h00, "rst_rd_wait");
        end
        @(negedge clk);
        check_out(1, 1'b1, 1'b1, 8'h77, "rst_rd_data");
        #2 rst_n = 1'b0;
        #1;
        check_out(1, 1'b0, 1'b0, 8'h00, "rst_async_drop");
        req[1] = 1'b0;
        @(negedge clk);
        check_out(1, 1'b0, 1'b0, 8'h00, "rst_held");
        rst_n = 1'b1;
        clear_model();
        run_txn(1, 1'b0, 8'h03, 8'h00, 8'h00, 0, 1'b0, c1);
        run_txn(0, 1'b0, 8'h0A, 8'h00, 8'h00, 0, 1'b0, c1);
        run_txn(1, 1'b0, 8'h0F, 8'h00, 8'h00, 0, 1'b0, c1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
